// File: rtl/m_rf_mp_if.sv
// Bundle for the multi-port register file: decode-side read addresses, writeback-side
// write ports and status outputs. clk/rst stay outside as plain ports.
interface m_rf_mp_if #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int NRD  = 2
);
  localparam int AW = $clog2(NREG);

  logic [NRD*AW-1:0]   w_ra;
  logic [NRD*XLEN-1:0] w_rd;
  logic                w_we0;
  logic [AW-1:0]       w_wa0;
  logic [XLEN-1:0]     w_wd0;
  logic                w_we1;
  logic [AW-1:0]       w_wa1;
  logic [XLEN-1:0]     w_wd1;
  logic                w_busy;
  logic                w_halt;
  logic [31:0]         w_wcnt;

  modport master (
    output w_ra, w_we0, w_wa0, w_wd0, w_we1, w_wa1, w_wd1,
    input  w_rd, w_busy, w_halt, w_wcnt
  );

  modport slave (
    input  w_ra, w_we0, w_wa0, w_wd0, w_we1, w_wa1, w_wd1,
    output w_rd, w_busy, w_halt, w_wcnt
  );
endinterface

// File: rtl/m_rf_mp.sv
// Multi-port integer register file: two prioritised write ports, NRD combinational
// read ports with optional write bypass, post-reset clear engine and sticky halt flag.
module m_rf_mp #(
  parameter int XLEN     = 32,
  parameter int NREG     = 32,
  parameter int NRD      = 2,
  parameter int BYPASS   = 1,
  parameter int HALT_REG = 30
) (
  input  logic       w_clk,
  input  logic       w_rst,
  m_rf_mp_if.slave   bus
);
  localparam int AW = $clog2(NREG);

  typedef enum logic {CLR, RUN} state_t;

  state_t              state;
  logic                busy;
  logic                halt;
  logic [AW-1:0]       cnt;
  logic [31:0]         wcnt;
  logic [XLEN-1:0]     mem [NREG];

  logic                cmt0;
  logic                cmt1;
  logic [1:0]          ncmt;
  logic                halt_hit;
  logic [AW-1:0]       ra_k;
  logic [NRD*XLEN-1:0] rd_all;

  // x0 is hardwired to zero, so writes to it never commit.
  assign cmt0 = ~busy & bus.w_we0 & (bus.w_wa0 != '0);
  assign cmt1 = ~busy & bus.w_we1 & (bus.w_wa1 != '0);
  assign ncmt = {1'b0, cmt0} + {1'b0, cmt1};

  assign halt_hit = (HALT_REG != 0) &&
                    ((cmt0 && (int'(bus.w_wa0) == HALT_REG)) ||
                     (cmt1 && (int'(bus.w_wa1) == HALT_REG)));

  always_ff @(posedge w_clk) begin
    if (w_rst) begin
      state <= CLR;
      busy  <= 1'b1;
      cnt   <= '0;
      halt  <= 1'b0;
      wcnt  <= '0;
    end else begin
      case (state)
        CLR: begin
          cnt <= cnt + AW'(1);
          if (cnt == AW'(NREG - 1)) begin
            state <= RUN;
            busy  <= 1'b0;
          end
        end
        RUN: begin
          wcnt <= wcnt + 32'(ncmt);
          if (halt_hit) halt <= 1'b1;
        end
        default: begin
          state <= CLR;
          busy  <= 1'b1;
          cnt   <= '0;
        end
      endcase
    end
  end

  // Port 1 is written last so it wins a same-address collision.
  always_ff @(posedge w_clk) begin
    if (!w_rst) begin
      if (busy) begin
        mem[cnt] <= '0;
      end else begin
        if (cmt0) mem[bus.w_wa0] <= bus.w_wd0;
        if (cmt1) mem[bus.w_wa1] <= bus.w_wd1;
      end
    end
  end

  always_comb begin
    rd_all = '0;
    ra_k   = '0;
    for (int k = 0; k < NRD; k++) begin
      ra_k = bus.w_ra[k*AW +: AW];
      if (busy || ra_k == '0)
        rd_all[k*XLEN +: XLEN] = '0;
      else if ((BYPASS != 0) && cmt1 && (bus.w_wa1 == ra_k))
        rd_all[k*XLEN +: XLEN] = bus.w_wd1;
      else if ((BYPASS != 0) && cmt0 && (bus.w_wa0 == ra_k))
        rd_all[k*XLEN +: XLEN] = bus.w_wd0;
      else
        rd_all[k*XLEN +: XLEN] = mem[ra_k];
    end
  end

  assign bus.w_rd   = rd_all;
  assign bus.w_busy = busy;
  assign bus.w_halt = halt;
  assign bus.w_wcnt = wcnt;
endmodule

// File: tb/tb_m_rf_mp.sv
// Bench for m_rf_mp: three 32x32 variants (bypass, no bypass, no halt) share stimulus,
// plus a 16x64 three-read-port variant; all checked against array models.
module tb_m_rf_mp;
  logic w_clk;
  logic rst;

  // Stimulus shared by the three 32-bit instances
  logic        we0, we1;
  logic [4:0]  wa0, wa1;
  logic [31:0] wd0, wd1;
  logic [9:0]  ra;

  // Stimulus for the wide instance
  logic        ww_we0, ww_we1;
  logic [3:0]  ww_wa0, ww_wa1;
  logic [63:0] ww_wd0, ww_wd1;
  logic [11:0] ww_ra;

  int n_chk  = 0;
  int n_pass = 0;

  // Reference models
  logic [31:0] mm [32];
  int unsigned mcnt;
  bit          mhalt;
  logic [63:0] mw [16];
  int unsigned wcnt_w;

  m_rf_mp_if #(.XLEN(32), .NREG(32), .NRD(2)) bm ();
  m_rf_mp_if #(.XLEN(32), .NREG(32), .NRD(2)) bn ();
  m_rf_mp_if #(.XLEN(32), .NREG(32), .NRD(2)) bh ();
  m_rf_mp_if #(.XLEN(64), .NREG(16), .NRD(3)) bw ();

  m_rf_mp #(.XLEN(32), .NREG(32), .NRD(2), .BYPASS(1), .HALT_REG(30))
    u_main  (.w_clk(w_clk), .w_rst(rst), .bus(bm));
  m_rf_mp #(.XLEN(32), .NREG(32), .NRD(2), .BYPASS(0), .HALT_REG(30))
    u_nobyp (.w_clk(w_clk), .w_rst(rst), .bus(bn));
  m_rf_mp #(.XLEN(32), .NREG(32), .NRD(2), .BYPASS(1), .HALT_REG(0))
    u_nohlt (.w_clk(w_clk), .w_rst(rst), .bus(bh));
  m_rf_mp #(.XLEN(64), .NREG(16), .NRD(3), .BYPASS(1), .HALT_REG(0))
    u_wide  (.w_clk(w_clk), .w_rst(rst), .bus(bw));

  assign bm.w_ra = ra;  assign bn.w_ra = ra;  assign bh.w_ra = ra;
  assign bm.w_we0 = we0; assign bn.w_we0 = we0; assign bh.w_we0 = we0;
  assign bm.w_wa0 = wa0; assign bn.w_wa0 = wa0; assign bh.w_wa0 = wa0;
  assign bm.w_wd0 = wd0; assign bn.w_wd0 = wd0; assign bh.w_wd0 = wd0;
  assign bm.w_we1 = we1; assign bn.w_we1 = we1; assign bh.w_we1 = we1;
  assign bm.w_wa1 = wa1; assign bn.w_wa1 = wa1; assign bh.w_wa1 = wa1;
  assign bm.w_wd1 = wd1; assign bn.w_wd1 = wd1; assign bh.w_wd1 = wd1;

  assign bw.w_ra  = ww_ra;
  assign bw.w_we0 = ww_we0; assign bw.w_wa0 = ww_wa0; assign bw.w_wd0 = ww_wd0;
  assign bw.w_we1 = ww_we1; assign bw.w_wa1 = ww_wa1; assign bw.w_wd1 = ww_wd1;

  initial w_clk = 1'b0;
  always #5 w_clk = ~w_clk;

  task automatic tick();
    @(posedge w_clk);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) mm[i] = '0;
    for (int i = 0; i < 16; i++) mw[i] = '0;
    mcnt = 0; mhalt = 0; wcnt_w = 0;
  endtask

  // Apply the commit rule for the current 32-bit write inputs; port 1 last wins.
  task automatic upd32();
    if (we0 && wa0 != 0) begin mm[wa0] = wd0; mcnt++; if (wa0 == 30) mhalt = 1; end
    if (we1 && wa1 != 0) begin mm[wa1] = wd1; mcnt++; if (wa1 == 30) mhalt = 1; end
  endtask

  task automatic updw();
    if (ww_we0 && ww_wa0 != 0) begin mw[ww_wa0] = ww_wd0; wcnt_w++; end
    if (ww_we1 && ww_wa1 != 0) begin mw[ww_wa1] = ww_wd1; wcnt_w++; end
  endtask

  function automatic logic [31:0] exp32(input logic [4:0] a, input bit byp);
    if (a == 0) return 32'h0;
    if (byp && we1 && wa1 == a) return wd1;
    if (byp && we0 && wa0 == a) return wd0;
    return mm[a];
  endfunction

  function automatic logic [63:0] expw(input logic [3:0] a);
    if (a == 0) return 64'h0;
    if (ww_we1 && ww_wa1 == a) return ww_wd1;
    if (ww_we0 && ww_wa0 == a) return ww_wd0;
    return mw[a];
  endfunction

  task automatic wait_clear(output int n, output int nw);
    n = 0; nw = 0;
    while (bm.w_busy === 1'b1 && n < 100) begin
      if (bw.w_busy === 1'b1) nw++;
      n++;
      tick();
    end
  endtask

  task automatic test_reset();
    int n, nw;
    we0 = 0; we1 = 0; ww_we0 = 0; ww_we1 = 0; ra = {5'd4, 5'd9}; ww_ra = '0;
    rst = 1; tick(); tick(); rst = 0;
    model_reset();
    n_chk++;
    if (bm.w_rd !== 64'h0 || bm.w_busy !== 1'b1)
      $display("FAIL reset_busy_rd: busy=%b rd=%h required busy=1 rd=0", bm.w_busy, bm.w_rd);
    else n_pass++;
    wait_clear(n, nw);
    n_chk++;
    if (n !== 32) $display("FAIL clear_len32: got %0d required 32", n); else n_pass++;
    n_chk++;
    if (nw !== 16) $display("FAIL clear_len16: got %0d required 16", nw); else n_pass++;
    n_chk++;
    if (bm.w_halt !== 1'b0 || bm.w_wcnt !== 32'd0)
      $display("FAIL reset_state: halt=%b wcnt=%0d required 0/0", bm.w_halt, bm.w_wcnt);
    else n_pass++;
    for (int a = 0; a < 32; a++) begin
      ra = {5'd0, 5'(a)}; #1;
      n_chk++;
      if (bm.w_rd[31:0] !== 32'h0)
        $display("FAIL reset_clear x%0d: got %h required 0", a, bm.w_rd[31:0]);
      else n_pass++;
    end
  endtask

  task automatic test_write_read();
    logic [4:0] a;
    we0 = 1; wa0 = 5; wd0 = 32'hDEADBEEF; ra = {5'd0, 5'd5}; #2;
    upd32(); tick(); we0 = 0; #2;
    n_chk++;
    if (bm.w_rd[31:0] !== 32'hDEADBEEF || bm.w_wcnt !== 32'd1)
      $display("FAIL wr_x5: rd=%h wcnt=%0d required deadbeef/1", bm.w_rd[31:0], bm.w_wcnt);
    else n_pass++;
    we0 = 1; wa0 = 0; wd0 = 32'h1234; ra = '0; #2;
    upd32(); tick(); we0 = 0; #2;
    n_chk++;
    if (bm.w_rd[31:0] !== 32'h0 || bm.w_wcnt !== 32'd1)
      $display("FAIL wr_x0: rd=%h wcnt=%0d required 0/1", bm.w_rd[31:0], bm.w_wcnt);
    else n_pass++;
    for (int i = 0; i < 60; i++) begin
      we0 = 1'($urandom); wa0 = 5'($urandom_range(0, 29)); wd0 = $urandom();
      we1 = 1'($urandom); wa1 = 5'($urandom_range(0, 29)); wd1 = $urandom();
      if (i % 4 == 0) wa1 = wa0;
      ra = {5'($urandom_range(0, 29)), (i % 3 == 0) ? wa0 : 5'($urandom_range(0, 29))};
      #2;
      for (int p = 0; p < 2; p++) begin
        a = ra[p*5 +: 5];
        n_chk++;
        if (bm.w_rd[p*32 +: 32] !== exp32(a, 1'b1))
          $display("FAIL rand_byp p%0d x%0d: got %h required %h", p, a, bm.w_rd[p*32 +: 32], exp32(a, 1'b1));
        else n_pass++;
        n_chk++;
        if (bn.w_rd[p*32 +: 32] !== exp32(a, 1'b0))
          $display("FAIL rand_nobyp p%0d x%0d: got %h required %h", p, a, bn.w_rd[p*32 +: 32], exp32(a, 1'b0));
        else n_pass++;
      end
      upd32(); tick();
      n_chk++;
      if (bm.w_wcnt !== mcnt || bn.w_wcnt !== mcnt || bh.w_wcnt !== mcnt)
        $display("FAIL rand_wcnt: got %0d required %0d", bm.w_wcnt, mcnt);
      else n_pass++;
    end
    we0 = 0; we1 = 0;
    for (int r = 1; r < 32; r++) begin
      ra = {5'(r), 5'(r)}; #1;
      n_chk++;
      if (bm.w_rd[63:32] !== mm[r] || bh.w_rd[31:0] !== mm[r])
        $display("FAIL sweep x%0d: got %h required %h", r, bm.w_rd[63:32], mm[r]);
      else n_pass++;
    end
  endtask

  task automatic test_same_addr();
    logic [31:0] old;
    int unsigned c0;
    old = mm[7]; c0 = mcnt;
    we0 = 1; wa0 = 7; wd0 = 32'h11; we1 = 1; wa1 = 7; wd1 = 32'h22; ra = {5'd0, 5'd7}; #2;
    n_chk++;
    if (bm.w_rd[31:0] !== 32'h22) $display("FAIL same_byp: got %h required 22", bm.w_rd[31:0]);
    else n_pass++;
    n_chk++;
    if (bn.w_rd[31:0] !== old) $display("FAIL same_nobyp: got %h required %h", bn.w_rd[31:0], old);
    else n_pass++;
    upd32(); tick(); we0 = 0; we1 = 0; #2;
    n_chk++;
    if (bm.w_rd[31:0] !== 32'h22 || bn.w_rd[31:0] !== 32'h22)
      $display("FAIL same_store: got %h/%h required 22", bm.w_rd[31:0], bn.w_rd[31:0]);
    else n_pass++;
    n_chk++;
    if (bm.w_wcnt !== c0 + 2) $display("FAIL same_wcnt: got %0d required %0d", bm.w_wcnt, c0 + 2);
    else n_pass++;
  endtask

  task automatic test_busy_write();
    int n, nw;
    rst = 1; tick(); rst = 0;
    for (int c = 1; c <= 10; c++) begin
      we0 = (c == 3); wa0 = 9; wd0 = 32'hAA; ra = {5'd9, 5'd9};
      if (c == 10) rst = 1;
      #2;
      if (c == 3) begin
        n_chk++;
        if (bm.w_rd !== 64'h0) $display("FAIL busy_rd: got %h required 0", bm.w_rd);
        else n_pass++;
      end
      tick();
    end
    rst = 0; we0 = 0;
    model_reset();
    wait_clear(n, nw);
    n_chk++;
    if (n !== 32) $display("FAIL restart_len: got %0d required 32", n); else n_pass++;
    #1;
    n_chk++;
    if (bm.w_rd[31:0] !== 32'h0 || bm.w_wcnt !== 32'd0)
      $display("FAIL busy_write_ignored: rd=%h wcnt=%0d required 0/0", bm.w_rd[31:0], bm.w_wcnt);
    else n_pass++;
  endtask

  task automatic test_halt();
    int n, nw;
    n_chk++;
    if (bm.w_halt !== 1'b0) $display("FAIL halt_pre: got %b required 0", bm.w_halt); else n_pass++;
    we1 = 1; wa1 = 30; wd1 = 32'h1; #2;
    upd32(); tick(); we1 = 0;
    n_chk++;
    if (bm.w_halt !== 1'b1 || bn.w_halt !== 1'b1)
      $display("FAIL halt_set: got %b/%b required 1", bm.w_halt, bn.w_halt);
    else n_pass++;
    for (int i = 0; i < 6; i++) begin
      we0 = 1; wa0 = 5'($urandom_range(1, 29)); wd0 = $urandom();
      upd32(); tick();
      n_chk++;
      if (bm.w_halt !== 1'b1 || bh.w_halt !== 1'b0)
        $display("FAIL halt_sticky: main=%b nohalt=%b required 1/0", bm.w_halt, bh.w_halt);
      else n_pass++;
    end
    we0 = 0;
    ra = {5'd30, 5'd30}; #1;
    n_chk++;
    if (bm.w_rd[31:0] !== 32'h1 || bh.w_rd[31:0] !== 32'h1)
      $display("FAIL halt_data: got %h required 1", bm.w_rd[31:0]);
    else n_pass++;
    we0 = 1; wa0 = 3; wd0 = 32'h55;
    rst = 1; tick(); rst = 0; we0 = 0;
    model_reset();
    n_chk++;
    if (bm.w_halt !== 1'b0 || bm.w_wcnt !== 32'd0 || bm.w_busy !== 1'b1)
      $display("FAIL halt_reset: halt=%b wcnt=%0d busy=%b required 0/0/1", bm.w_halt, bm.w_wcnt, bm.w_busy);
    else n_pass++;
    wait_clear(n, nw);
    n_chk++;
    if (n > 32) $display("FAIL halt_clear: got %0d required <=32", n); else n_pass++;
  endtask

  task automatic test_wide();
    logic [3:0] a;
    ww_we0 = 1; ww_wa0 = 3; ww_wd0 = 64'h0123456789ABCDEF;
    ww_we1 = 1; ww_wa1 = 15; ww_wd1 = 64'hFFFFFFFFFFFFFFFF;
    ww_ra = {4'd0, 4'd15, 4'd3}; #2;
    updw(); tick(); ww_we0 = 0; ww_we1 = 0; #2;
    n_chk++;
    if (bw.w_rd !== {64'h0, 64'hFFFFFFFFFFFFFFFF, 64'h0123456789ABCDEF})
      $display("FAIL wide_dir: got %h", bw.w_rd);
    else n_pass++;
    for (int i = 0; i < 30; i++) begin
      ww_we0 = 1'($urandom); ww_wa0 = 4'($urandom); ww_wd0 = {$urandom(), $urandom()};
      ww_we1 = 1'($urandom); ww_wa1 = 4'($urandom); ww_wd1 = {$urandom(), $urandom()};
      ww_ra = {4'($urandom), ww_wa1, 4'($urandom)}; #2;
      for (int p = 0; p < 3; p++) begin
        a = ww_ra[p*4 +: 4];
        n_chk++;
        if (bw.w_rd[p*64 +: 64] !== expw(a))
          $display("FAIL wide_rd p%0d x%0d: got %h required %h", p, a, bw.w_rd[p*64 +: 64], expw(a));
        else n_pass++;
      end
      updw(); tick();
      n_chk++;
      if (bw.w_wcnt !== wcnt_w || bw.w_halt !== 1'b0)
        $display("FAIL wide_wcnt: got %0d halt=%b required %0d/0", bw.w_wcnt, bw.w_halt, wcnt_w);
      else n_pass++;
    end
    ww_we0 = 0; ww_we1 = 0;
  endtask

  initial begin
    rst = 1; we0 = 0; we1 = 0; wa0 = 0; wa1 = 0; wd0 = 0; wd1 = 0; ra = 0;
    ww_we0 = 0; ww_we1 = 0; ww_wa0 = 0; ww_wa1 = 0; ww_wd0 = 0; ww_wd1 = 0; ww_ra = 0;
    test_reset();
    test_write_read();
    test_same_addr();
    test_busy_write();
    test_halt();
    test_wide();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/m_rf_mp.md
Name: m_rf_mp

Overview:
Parametrised multi-port integer register file, successor to the single-write, two-read RV32 register file used by the core.
- Width, depth and read-port count are parametrised.
- Two write ports with fixed priority and optional same-cycle write-to-read bypass.
- A sequential clear engine runs after reset, and a sticky halt flag replaces simulation-only termination.
- Sits between decode (read addresses) and writeback (write ports) in the pipelined core.

Parameters:
XLEN, 32, data width in bits
NREG, 32, number of registers; power of 2, >= 2; AW = clog2(NREG) localparam
NRD, 2, number of read ports, >= 1
BYPASS, 1, 1 = same-cycle write data forwarded to reads; 0 = reads see pre-edge contents
HALT_REG, 30, register index whose write raises w_halt; 0 disables halt detection

Ports:
w_clk  input  1  clock, all state updates on rising edge
w_rst  input  1  synchronous reset, active-high
w_ra  input  NRD*AW  read addresses; port k at bits [k*AW +: AW]
w_rd  output  NRD*XLEN  read data; port k at bits [k*XLEN +: XLEN]
w_we0  input  1  write enable, port 0
w_wa0  input  AW  write address, port 0
w_wd0  input  XLEN  write data, port 0
w_we1  input  1  write enable, port 1 (higher priority)
w_wa1  input  AW  write address, port 1
w_wd1  input  XLEN  write data, port 1
w_busy  output  1  clear engine active; writes ignored, reads return 0
w_halt  output  1  sticky; write to HALT_REG has committed
w_wcnt  output  32  count of committed register writes, wraps at 2^32

Behaviour:
- States: CLR, RUN.
- Reset: w_rst=1 at an edge gives state=CLR, clear counter=0, w_halt=0, w_wcnt=0. Reset is mandatory after power-up; state before the first reset is undefined.
- CLR state:
  - Each edge writes mem[cnt]=0 and increments cnt.
  - On the edge where cnt==NREG-1, mem[NREG-1] is cleared and state goes to RUN.
  - The clear therefore takes exactly NREG cycles after the reset edge.
  - w_rst reasserted mid-clear restarts at cnt=0.
- w_busy = (state==CLR), registered decode. It is 1 from the edge after w_rst is sampled high through the last clear cycle.
- While busy:
  - all w_rd = 0;
  - w_we0/w_we1 are ignored and not counted;
  - w_halt is not set.
- Commit rule (RUN only): port p commits when w_wep=1 and w_wap!=0.
  - Writes to x0 are discarded and not counted.
  - If both ports commit to the same address, port 1's data is stored. Both commits are still counted (+2).
- w_wcnt increments by the number of committed ports (0, 1 or 2) per edge, modulo 2^32.
- Read port k (combinational):
  - if busy or ra_k==0: 0;
  - else if BYPASS=1 and port-1 commit to ra_k this cycle: w_wd1;
  - else if BYPASS=1 and port-0 commit to ra_k this cycle: w_wd0;
  - else mem[ra_k].
- All NRD read ports are independent and may read the same address.
- w_halt:
  - set on the edge where either port commits to HALT_REG (HALT_REG!=0, RUN state);
  - stays 1 until reset;
  - the write itself completes normally.
- w_rst has priority over any same-cycle write. The write is dropped and w_wcnt is cleared.

Test Plan:
- Reset, NREG=32: assert w_rst 1 cycle -> w_busy=1 for exactly 32 cycles then 0. All w_rd=0 after, w_halt=0, w_wcnt=0.
- Write port0 x5=0xDEADBEEF, next cycle read ra0=5 -> w_rd[0]=0xDEADBEEF, w_wcnt=1. Write x0=0x1234 -> ra=0 reads 0, w_wcnt unchanged.
- Same cycle w_we0 x7=0x11, w_we1 x7=0x22 -> x7=0x22, w_wcnt +2. With BYPASS=1, ra0=7 in that cycle reads 0x22; with BYPASS=0 it reads the old value.
- Write during busy (cycle 3 of clear), x9=0xAA -> ignored. x9 reads 0 after clear, w_wcnt=0. Reassert w_rst at clear cycle 10 -> busy lasts 32 more cycles.
- Write x30=1 via port1 -> w_halt=1 next cycle and stays 1 through further writes. w_rst clears it. HALT_REG=0 instance: write x30 -> w_halt stays 0.
- NRD=3, XLEN=64, NREG=16: x3=0x0123456789ABCDEF, x15=-1; ra={3,15,0} -> w_rd={0x0123456789ABCDEF, 0xFFFFFFFFFFFFFFFF, 0} (ports 0,1,2).
